// File: rtl/fwd_router_3way.sv
// Three-way packet forwarder: decodes dx/dy hop fields and queues each packet in one of
// three first-word-fall-through FIFOs. Optional drop counter enabled by FWD_ROUTER_DROP_CNT_EN.
module fwd_router_3way #(
    parameter int DATA_WIDTH = 32,
    parameter int DX_MSB     = 29,
    parameter int DX_LSB     = 21,
    parameter int DY_MSB     = 20,
    parameter int DY_LSB     = 12,
    parameter int ADD        = -1,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wen,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DX_LSB-1:0]     dout_b,
    output logic [DX_LSB-1:0]     dout_c,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  valid_c,
    input  logic                  ren_a,
    input  logic                  ren_b,
    input  logic                  ren_c,
    output logic [15:0]           drop_cnt
);

    localparam int DXW   = DX_MSB - DX_LSB + 1;
    localparam int DYW   = DY_MSB - DY_LSB + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DXW-1:0]      AddTrunc = DXW'(ADD);
    localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DXW-1:0]        dx;
    logic [DYW-1:0]        dy;
    logic                  dy_neg;
    logic [2:0]            tgt;
    logic [2:0]            full_vec;
    logic [2:0]            valid_vec;
    logic [2:0]            push;
    logic [2:0]            pop;
    logic [2:0]            ren;
    logic [DATA_WIDTH-1:0] a_entry;

    logic [DEPTH_LOG2-1:0] wptr [3];
    logic [DEPTH_LOG2-1:0] rptr [3];
    logic [DEPTH_LOG2:0]   cnt  [3];

    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DX_LSB-1:0]     mem_b [DEPTH];
    logic [DX_LSB-1:0]     mem_c [DEPTH];

    assign dx     = din[DX_MSB:DX_LSB];
    assign dy     = din[DY_MSB:DY_LSB];
    assign dy_neg = $signed(dy) < 0;
    assign ren    = {ren_c, ren_b, ren_a};

    // Index 0 = A (straight), 1 = B (north, dy >= 0), 2 = C (south, dy < 0).
    assign tgt = {(dx == '0) && dy_neg, (dx == '0) && !dy_neg, dx != '0};

    always_comb begin
        a_entry = din;
        a_entry[DX_MSB:DX_LSB] = dx + AddTrunc;
    end

    always_comb begin
        full_vec  = '0;
        valid_vec = '0;
        for (int i = 0; i < 3; i++) begin
            full_vec[i]  = (cnt[i] == DepthCnt);
            valid_vec[i] = (cnt[i] != '0);
        end
    end

    // Admission uses start-of-cycle occupancy, so a same-cycle pop never frees a slot.
    assign full = |(tgt & full_vec);
    assign push = {3{wen}} & tgt & ~full_vec;
    assign pop  = ren & valid_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
                if (push[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push[0]) mem_a[wptr[0]] <= a_entry;
        if (push[1]) mem_b[wptr[1]] <= din[DX_LSB-1:0];
        if (push[2]) mem_c[wptr[2]] <= din[DX_LSB-1:0];
    end

    // Storage is not reset; gating with valid keeps empty outputs at zero.
    assign valid_a = valid_vec[0];
    assign valid_b = valid_vec[1];
    assign valid_c = valid_vec[2];
    assign dout_a  = valid_vec[0] ? mem_a[rptr[0]] : '0;
    assign dout_b  = valid_vec[1] ? mem_b[rptr[1]] : '0;
    assign dout_c  = valid_vec[2] ? mem_c[rptr[2]] : '0;

`ifdef FWD_ROUTER_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = wen & full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_router_3way.sv
// Directed bench for fwd_router_3way: per-FIFO scoreboard queues filled on accepted writes,
// compared against the FIFO heads every cycle.
module tb_fwd_router_3way;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        wen = 1'b0;
    logic        full;
    logic [31:0] dout_a;
    logic [20:0] dout_b;
    logic [20:0] dout_c;
    logic        valid_a, valid_b, valid_c;
    logic        ren_a = 1'b0, ren_b = 1'b0, ren_c = 1'b0;
    logic [15:0] drop_cnt;

    int compared   = 0;
    int mismatched = 0;
    int drops      = 0;

    logic [31:0] qa [$];
    logic [20:0] qb [$];
    logic [20:0] qc [$];

    fwd_router_3way dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .wen      (wen),
        .full     (full),
        .dout_a   (dout_a),
        .dout_b   (dout_b),
        .dout_c   (dout_c),
        .valid_a  (valid_a),
        .valid_b  (valid_b),
        .valid_c  (valid_c),
        .ren_a    (ren_a),
        .ren_b    (ren_b),
        .ren_c    (ren_c),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int dx, input int dy, input logic [11:0] low);
        logic [8:0] x;
        logic [8:0] y;
        x = dx[8:0];
        y = dy[8:0];
        return {2'b10, x, y, low};
    endfunction

    function automatic int tgt_of(input logic [31:0] d);
        if (d[29:21] != 9'd0) return 0;
        return d[20] ? 2 : 1;
    endfunction

    function automatic int qsize(input int t);
        if (t == 0) return qa.size();
        if (t == 1) return qb.size();
        return qc.size();
    endfunction

    function automatic logic [15:0] exp_drops();
`ifdef FWD_ROUTER_DROP_CNT_EN
        return drops[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_outputs();
        chk("valid_a", {31'd0, valid_a}, {31'd0, qa.size() != 0});
        chk("valid_b", {31'd0, valid_b}, {31'd0, qb.size() != 0});
        chk("valid_c", {31'd0, valid_c}, {31'd0, qc.size() != 0});
        chk("dout_a", dout_a, (qa.size() != 0) ? qa[0] : 32'd0);
        chk("dout_b", {11'd0, dout_b}, {11'd0, (qb.size() != 0) ? qb[0] : 21'd0});
        chk("dout_c", {11'd0, dout_c}, {11'd0, (qc.size() != 0) ? qc[0] : 21'd0});
        chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, exp_drops()});
    endtask

    // One clock: drive at negedge, check heads and full, then update the model after the edge.
    task automatic step(input logic w, input logic [31:0] d, input logic ra, input logic rb,
                        input logic rc);
        int          t;
        logic        f_exp;
        logic [2:0]  p;
        logic [31:0] e;
        @(negedge clk);
        din = d; wen = w; ren_a = ra; ren_b = rb; ren_c = rc;
        #1;
        check_outputs();
        t     = tgt_of(d);
        f_exp = (qsize(t) == 4);
        chk("full", {31'd0, full}, {31'd0, f_exp});
        p = {rc && qc.size() != 0, rb && qb.size() != 0, ra && qa.size() != 0};
        @(posedge clk);
        #1;
        wen = 1'b0; ren_a = 1'b0; ren_b = 1'b0; ren_c = 1'b0;
        if (p[0]) void'(qa.pop_front());
        if (p[1]) void'(qb.pop_front());
        if (p[2]) void'(qc.pop_front());
        if (w && f_exp) begin
            if (drops < 65535) drops++;
        end else if (w) begin
            e = d;
            e[29:21] = d[29:21] - 9'd1;
            if (t == 0) qa.push_back(e);
            else if (t == 1) qb.push_back(d[20:0]);
            else qc.push_back(d[20:0]);
        end
    endtask

    initial begin
        // Reset state, observed while rst is still held.
        #2;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Straight-through with dx decrement.
        step(1'b1, mk(3, 0, 12'hABC), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("dx_field", {23'd0, dout_a[29:21]}, 32'd2);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // South then north.
        step(1'b1, mk(0, -5, 12'h123), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 4, 12'h456), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // Fill A; fifth write is dropped while a pop is ignored for admission.
        for (int k = 0; k < 4; k++) step(1'b1, mk(k + 1, k, 12'(k * 7)), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(-7, 2, 12'hFFF), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(9, 1, 12'h0EE), 1'b1, 1'b0, 1'b0);

        // A has space again; B is independent of A.
        step(1'b1, mk(0, 1, 12'h777), 1'b0, 1'b0, 1'b0);

        // Drain A to two entries, then steady push+pop across pointer wrap.
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, mk(-(k + 2), k, 12'(k + 100)), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Pops on empty FIFOs must be ignored.
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset with three buffered entries.
        step(1'b1, mk(5, 5, 12'h011), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 6, 12'h022), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, -6, 12'h033), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
        chk("rst_valid_b", {31'd0, valid_b}, 32'd0);
        chk("rst_valid_c", {31'd0, valid_c}, 32'd0);
        chk("rst_dout_a", dout_a, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        qa.delete(); qb.delete(); qc.delete();
        drops = 0;
        @(negedge clk);
        rst = 1'b0;

        // First write after reset behaves as from reset.
        step(1'b1, mk(0, 7, 12'h5A5), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1, 0, 12'h0F0), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_router_3way.md
FWD_ROUTER_3WAY -- requirements
Module: fwd_router_3way

Interface
REQ-001 Parameter DATA_WIDTH, default 32, packet width in bits.
REQ-002 Parameter DX_MSB / DX_LSB, default 29 / 21, bit range of the signed dx hop field.
REQ-003 Parameter DY_MSB / DY_LSB, default 20 / 12, bit range of the signed dy hop field.
REQ-004 Parameter ADD, default -1, constant added to dx on east/west forwarding (-1 east, +1 west).
REQ-005 Parameter DEPTH_LOG2, default 2, per-output FIFO depth = 2**DEPTH_LOG2 entries.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 din  input  DATA_WIDTH  incoming packet.
REQ-009 wen  input  1  write strobe for din.
REQ-010 full  output  1  combinational; high when the FIFO that din decodes to is full.
REQ-011 dout_a  output  DATA_WIDTH  head of FIFO A (straight-through port).
REQ-012 dout_b, dout_c  output  DX_LSB each  heads of FIFO B (north) and FIFO C (south).
REQ-013 valid_a, valid_b, valid_c  output  1 each  FIFO non-empty.
REQ-014 ren_a, ren_b, ren_c  input  1 each  consumer pop strobes.
REQ-015 drop_cnt  output  16  rejected-write counter (see Configuration).

Function
REQ-016 Decode: dx==0 and dy>=0 targets B; dx==0 and dy<0 targets C; dx!=0 targets A.
REQ-017 Entry written to A SHALL be din with bits [DX_MSB:DX_LSB] replaced by (dx+ADD) truncated to field width, all other bits unchanged.
REQ-018 Entry written to B or C SHALL be din[DX_LSB-1:0].
REQ-019 Write accepted when wen=1 and target FIFO count < depth at the start of the cycle; a same-cycle pop on a full FIFO does not admit the write.
REQ-020 Write with wen=1 while target full is dropped; no FIFO state changes.
REQ-021 Each FIFO is first-word-fall-through: dout_x shows the oldest entry whenever valid_x=1; dout_x is don't-care-free, held at last value or zero when empty.
REQ-022 Latency: packet accepted on edge N appears with valid_x=1 after edge N (next cycle), zero idle cycles.
REQ-023 ren_x with valid_x=1 pops one entry on that edge; ren_x with valid_x=0 is ignored, pointers unchanged.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO keeps count unchanged and preserves order.
REQ-025 Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth; count is DEPTH_LOG2+1 bits.
REQ-026 FIFOs A, B, C operate independently; back-pressure on one SHALL not block packets bound for another.

Reset
REQ-027 rst=1 SHALL asynchronously clear all pointers and counts, force valid_a/b/c=0, dout_a/b/c=0, drop_cnt=0.
REQ-028 rst asserted mid-operation discards all buffered packets; first accepted write after deassertion behaves as from reset.

Configuration
REQ-029 Macro FWD_ROUTER_DROP_CNT_EN defined: drop_cnt increments by 1 per dropped write (REQ-020), saturating at 16'hFFFF.
REQ-030 Macro FWD_ROUTER_DROP_CNT_EN undefined: drop_cnt port present, tied to 16'h0000, no counter logic.

Verification
REQ-031 Defaults, din dx=3 dy=0, wen 1 cycle -> next cycle valid_a=1, dout_a dx field=2, other bits equal din.
REQ-032 din dx=0 dy=-5 then dx=0 dy=4 -> FIFO C holds first packet's low 21 bits, FIFO B the second; valid_a stays 0.
REQ-033 Five writes to A with ren_a=0, DEPTH_LOG2=2 -> full=1 on fifth, A holds first four in order; drop_cnt=1 with macro, 0 without.
REQ-034 A full, B empty, write dx=0 dy=1 -> accepted to B, valid_b=1 next cycle, full=0 for that din.
REQ-035 Steady push+pop on A for 10 cycles from count 2 -> count stays 2, outputs in input order across pointer wrap.
REQ-036 Three entries buffered, rst pulsed mid-cycle -> valid_a/b/c=0 and drop_cnt=0 immediately, before next clock edge.
